// File: rtl/alu_muldiv_pkg.sv
// alu_pkg: opcodes, mul/div FSM states and the mul/div opcode test shared by the ALU slice
package alu_pkg;
    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SLT   = 4'b0111;
    localparam logic [3:0] ALU_MULT  = 4'b1000;
    localparam logic [3:0] ALU_MULTU = 4'b1001;
    localparam logic [3:0] ALU_DIV   = 4'b1010;
    localparam logic [3:0] ALU_DIVU  = 4'b1011;
    localparam logic [3:0] ALU_NOR   = 4'b1100;
    localparam logic [3:0] ALU_MFHI  = 4'b1101;
    localparam logic [3:0] ALU_MFLO  = 4'b1110;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // MULT/MULTU/DIV/DIVU occupy 10xx; bit 1 selects divide, bit 0 selects unsigned
    function automatic logic is_muldiv(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction
endpackage

// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: EX-stage ALU bus; master drives a/b/alu_control/start, slave returns result/busy/done/div_by_zero/hi/lo
interface alu_muldiv_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       alu_control;
    logic             start;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    modport master (output a, b, alu_control, start, input result, busy, done, div_by_zero, hi, lo);
    modport slave  (input a, b, alu_control, start, output result, busy, done, div_by_zero, hi, lo);
endinterface

// File: rtl/alu_muldiv_iter.sv
// muldiv_iter: iterative shift-add multiply / restoring divide on magnitudes with sign fix-up
//   in : clk, reset, start, op, a, b
//   out: busy (RUN), done (DONE pulse), div_by_zero (sticky), wr (HI/LO write strobe), res ({HI,LO})
module muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic               div_by_zero,
    output logic               wr,
    output logic [2*WIDTH-1:0] res
);
    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, q, m;
    logic             is_div, neg_q, neg_r;
    logic             sgn, accept, zero_div, last;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   sum, shifted, diff;

    assign sgn      = ~op[0];
    assign accept   = state == IDLE && start && is_muldiv(op);
    assign zero_div = op[1] && b == '0;
    assign mag_a    = sgn && a[WIDTH-1] ? -a : a;
    assign mag_b    = sgn && b[WIDTH-1] ? -b : b;
    assign last     = cnt == CNT_W'(WIDTH);
    assign sum      = {1'b0, acc} + {1'b0, q[0] ? m : '0};
    assign shifted  = {acc, q[WIDTH-1]};
    // shifted < 2*divisor, so a W+1-bit difference keeps a valid sign bit
    assign diff     = shifted - {1'b0, m};

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state == IDLE ? (accept ? (zero_div ? DONE : RUN) : IDLE) :
                  state == RUN  ? (last ? DONE : RUN) : IDLE;
    end

    always_comb begin
        busy = state == RUN;
        done = state == DONE;
        wr   = (state == RUN && last) || (accept && zero_div);
        res  = state == IDLE ? {a, {WIDTH{1'b1}}} :
               is_div        ? {neg_r ? -acc : acc, neg_q ? -q : q} :
               neg_q         ? -{acc, q} : {acc, q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            div_by_zero <= 1'b0;
            acc         <= '0;
            q           <= '0;
            m           <= '0;
            is_div      <= 1'b0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
        end else if (accept) begin
            cnt         <= '0;
            div_by_zero <= zero_div;
            acc         <= '0;
            q           <= op[1] ? mag_a : mag_b;
            m           <= op[1] ? mag_b : mag_a;
            is_div      <= op[1];
            neg_q       <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r       <= sgn && op[1] && a[WIDTH-1];
        end else if (state == RUN && !last) begin
            cnt <= cnt + 1'b1;
            acc <= is_div ? (diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
            q   <= is_div ? {q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], q[WIDTH-1:1]};
        end
    end
endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: MIPS EX-stage ALU with combinational ops, HI/LO registers and iterative mul/div
//   in : clk, reset, bus.a, bus.b, bus.alu_control, bus.start
//   out: bus.result, bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        reset,
    alu_muldiv_if.slave bus
);
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               wr;
    logic [2*WIDTH-1:0] res;

    muldiv_iter #(.WIDTH(WIDTH)) u_iter (
        .clk         (clk),
        .reset       (reset),
        .start       (bus.start),
        .op          (bus.alu_control),
        .a           (bus.a),
        .b           (bus.b),
        .busy        (bus.busy),
        .done        (bus.done),
        .div_by_zero (bus.div_by_zero),
        .wr          (wr),
        .res         (res)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
        end else if (wr) begin
            {hi_q, lo_q} <= res;
        end
    end

    always_comb begin
        case (bus.alu_control)
            ALU_AND:  bus.result = bus.a & bus.b;
            ALU_OR:   bus.result = bus.a | bus.b;
            ALU_ADD:  bus.result = bus.a + bus.b;
            ALU_SUB:  bus.result = bus.a - bus.b;
            ALU_SLT:  bus.result = WIDTH'($signed(bus.a) < $signed(bus.b));
            ALU_NOR:  bus.result = ~(bus.a | bus.b);
            ALU_MFHI: bus.result = hi_q;
            ALU_MFLO: bus.result = lo_q;
            default:  bus.result = '0;
        endcase
    end

    assign bus.hi = hi_q;
    assign bus.lo = lo_q;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors for alu_muldiv with hand-computed expectations
module tb_alu_muldiv;
    import alu_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;

    alu_muldiv_if #(.WIDTH(32)) bus ();
    alu_muldiv #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // launch one mul/div op, wait for done (bounded), check busy length and HI/LO
    task automatic mdop(input string tag, input logic [3:0] op, input logic [31:0] ea, input logic [31:0] eb,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo, input int exp_busy);
        int nb = 0;
        int t = 0;
        @(negedge clk);
        bus.a = ea; bus.b = eb; bus.alu_control = op; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        check({tag, "_res0"}, bus.result, 32'h0);
        while (!bus.done && t < 100) begin
            if (bus.busy) nb++;
            @(negedge clk);
            #1;
            t++;
        end
        check({tag, "_done"}, {31'b0, bus.done}, 32'h1);
        check({tag, "_busy"}, nb, exp_busy);
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_lo"}, bus.lo, exp_lo);
        @(negedge clk);
    endtask

    logic [3:0]  sc_op  [8] = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR, ALU_SLT, ALU_SLT, 4'b0011};
    logic [31:0] sc_a   [8] = '{32'hF0, 32'hF0, 32'hF0, 32'hF0, 32'hF0, 32'hFFFF_FFFF, 32'h1, 32'hF0};
    logic [31:0] sc_b   [8] = '{32'hF0F, 32'hF0F, 32'hF0F, 32'hF0F, 32'hF0F, 32'h1, 32'hFFFF_FFFF, 32'hF0F};
    logic [31:0] sc_exp [8] = '{32'h0, 32'hFFF, 32'hFFF, 32'hFFFF_F1E1, 32'hFFFF_F000, 32'h1, 32'h0, 32'h0};

    initial begin
        int nd;
        int t;
        bus.a = '0; bus.b = '0; bus.alu_control = ALU_AND; bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, bus.busy}, 32'h0);
        check("rst_done", {31'b0, bus.done}, 32'h0);
        check("rst_dbz", {31'b0, bus.div_by_zero}, 32'h0);
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.a = sc_a[i]; bus.b = sc_b[i]; bus.alu_control = sc_op[i];
            #1;
            check($sformatf("sc%0d", i), bus.result, sc_exp[i]);
        end
        bus.a = 32'hFFFF_FFFF; bus.b = 32'h1; bus.alu_control = ALU_ADD;
        #1;
        check("add_wrap", bus.result, 32'h0);

        // start with a non-mul/div code is ignored
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_alu_ign", {31'b0, bus.busy | bus.done}, 32'h0);

        mdop("mult", ALU_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 33);
        mdop("multnn", ALU_MULT, 32'hFFFF_FFFB, 32'hFFFF_FFFA, 32'h0, 32'h1E, 33);
        mdop("multu", ALU_MULTU, 32'hFFFF_FFFF, 32'd2, 32'h1, 32'hFFFF_FFFE, 33);
        mdop("div", ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 33);
        mdop("divpn", ALU_DIV, 32'd7, 32'hFFFF_FFFE, 32'h1, 32'hFFFF_FFFD, 33);
        mdop("divu", ALU_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 33);
        mdop("divmin", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 33);

        mdop("dbz", ALU_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF, 0);
        check("dbz_flag", {31'b0, bus.div_by_zero}, 32'h1);
        repeat (2) @(negedge clk);
        check("dbz_sticky", {31'b0, bus.div_by_zero}, 32'h1);
        mdop("multu_clr", ALU_MULTU, 32'd3, 32'd4, 32'h0, 32'hC, 33);
        check("dbz_clr", {31'b0, bus.div_by_zero}, 32'h0);

        // ignored second start, MFLO while busy, MFHI in the done cycle, start in DONE ignored
        @(negedge clk);
        bus.a = 32'h1_0000; bus.b = 32'h1_0000; bus.alu_control = ALU_MULT; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        bus.a = 32'd1; bus.b = 32'd1; bus.alu_control = ALU_MULTU; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; bus.alu_control = ALU_MFLO;
        #1;
        check("busy_mid", {31'b0, bus.busy}, 32'h1);
        check("mflo_busy", bus.result, 32'hC);
        t = 0;
        while (!bus.done && t < 100) begin
            @(negedge clk);
            t++;
        end
        bus.alu_control = ALU_MFHI;
        #1;
        check("ign_done", {31'b0, bus.done}, 32'h1);
        check("mfhi_done", bus.result, 32'h1);
        check("ign_lo", bus.lo, 32'h0);
        bus.a = 32'd2; bus.b = 32'd2; bus.alu_control = ALU_MULTU; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check("start_done_ign", {31'b0, bus.busy}, 32'h0);
        check("no_overlap", {31'b0, bus.done}, 32'h0);

        // reset in the middle of a divide
        @(negedge clk);
        bus.a = 32'd100; bus.b = 32'd7; bus.alu_control = ALU_DIVU; bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rmid_busy", {31'b0, bus.busy}, 32'h0);
        check("rmid_hi", bus.hi, 32'h0);
        check("rmid_lo", bus.lo, 32'h0);
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) nd++;
        end
        check("rmid_quiet", nd, 0);
        mdop("multu_post", ALU_MULTU, 32'h1234_5678, 32'h10, 32'h1, 32'h2345_6780, 33);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
